// File: rtl/pulp_icache_fetch_adapter.sv
// Per-port fetch adapter between core req/gnt/rvalid fetch ports and the icache valid/ready ports.
// Optional stall counters are built only when PULP_ICACHE_FETCH_ADAPTER_PERF_EN is defined.
module pulp_icache_fetch_adapter #(
  parameter int unsigned NumFetchPorts  = 8,
  parameter int unsigned FetchAddrWidth = 32,
  parameter int unsigned FetchDataWidth = 32,
  parameter int unsigned ReqDepth       = 2,
  parameter int unsigned RspCut         = 0,
  parameter int unsigned CntWidth       = 16
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NumFetchPorts-1:0]                 fetch_req_i,
  input  logic [NumFetchPorts*FetchAddrWidth-1:0]  fetch_addr_i,
  output logic [NumFetchPorts-1:0]                 fetch_gnt_o,
  output logic [NumFetchPorts-1:0]                 fetch_rvalid_o,
  output logic [NumFetchPorts*FetchDataWidth-1:0]  fetch_rdata_o,
  output logic [NumFetchPorts-1:0]                 fetch_rerror_o,
  input  logic [NumFetchPorts-1:0]                 flush_valid_i,
  output logic [NumFetchPorts-1:0]                 flush_ready_o,
  output logic [NumFetchPorts-1:0]                 cache_valid_o,
  output logic [NumFetchPorts*FetchAddrWidth-1:0]  cache_addr_o,
  input  logic [NumFetchPorts-1:0]                 cache_ready_i,
  input  logic [NumFetchPorts*FetchDataWidth-1:0]  cache_rdata_i,
  input  logic [NumFetchPorts-1:0]                 cache_rerror_i,
  output logic [NumFetchPorts-1:0]                 cache_flush_valid_o,
  input  logic [NumFetchPorts-1:0]                 cache_flush_ready_i,
  input  logic                                     clear_cnt_i,
  output logic [NumFetchPorts*CntWidth-1:0]        stall_cnt_o
);

  localparam int unsigned PtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int unsigned CntW = $clog2(ReqDepth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(ReqDepth - 1);
  localparam logic [CntW-1:0] DepthC  = CntW'(ReqDepth);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_e;

`ifndef PULP_ICACHE_FETCH_ADAPTER_PERF_EN
  logic unused_clear_cnt;
  assign unused_clear_cnt = clear_cnt_i;
`endif

  for (genvar p = 0; p < NumFetchPorts; p++) begin : g_port
    logic [FetchAddrWidth-1:0] mem_q [ReqDepth];
    logic [FetchAddrWidth-1:0] head;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           count_q, count_d;
    state_e                    state_q;
    logic                      cfv_q, fr_q;
    logic                      gnt, pop, c_valid, rsp_pend;

    assign c_valid = (count_q != '0);
    assign pop     = c_valid & cache_ready_i[p];
    // Full check uses only the registered count, so gnt never depends on cache_ready_i.
    assign gnt     = fetch_req_i[p] & (count_q < DepthC) & (state_q == IDLE) & ~flush_valid_i[p];

    always_comb begin
      head = '0;
      for (int i = 0; i < int'(ReqDepth); i++) begin
        if (rd_ptr_q == PtrW'(i)) head = mem_q[i];
      end
    end

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (gnt) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      if (gnt && !pop)      count_d = count_q + 1'b1;
      else if (pop && !gnt) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
      for (int i = 0; i < int'(ReqDepth); i++) begin
        if (gnt && wr_ptr_q == PtrW'(i)) mem_q[i] <= fetch_addr_i[p*FetchAddrWidth +: FetchAddrWidth];
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    assign fetch_gnt_o[p]                                   = gnt;
    assign cache_valid_o[p]                                 = c_valid;
    assign cache_addr_o[p*FetchAddrWidth +: FetchAddrWidth] = c_valid ? head : '0;

    if (RspCut != 0) begin : g_rsp_cut
      logic                      rvalid_q, rerror_q;
      logic [FetchDataWidth-1:0] rdata_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rvalid_q <= 1'b0;
          rerror_q <= 1'b0;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= pop;
          if (pop) begin
            rdata_q  <= cache_rdata_i[p*FetchDataWidth +: FetchDataWidth];
            rerror_q <= cache_rerror_i[p];
          end
        end
      end

      assign fetch_rvalid_o[p]                                 = rvalid_q;
      assign fetch_rdata_o[p*FetchDataWidth +: FetchDataWidth] = rdata_q;
      assign fetch_rerror_o[p]                                 = rerror_q;
      assign rsp_pend                                          = rvalid_q;
    end else begin : g_rsp_comb
      assign fetch_rvalid_o[p]                                 = pop;
      assign fetch_rdata_o[p*FetchDataWidth +: FetchDataWidth] =
        pop ? cache_rdata_i[p*FetchDataWidth +: FetchDataWidth] : '0;
      assign fetch_rerror_o[p]                                 = pop & cache_rerror_i[p];
      assign rsp_pend                                          = 1'b0;
    end

    // Flush is forwarded only once no fetch is queued or still waiting in the response register.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= IDLE;
        cfv_q   <= 1'b0;
        fr_q    <= 1'b0;
      end else begin
        fr_q <= 1'b0;
        unique case (state_q)
          IDLE:  if (flush_valid_i[p]) state_q <= DRAIN;
          DRAIN: if (count_q == '0 && !rsp_pend) begin
                   state_q <= FLUSH;
                   cfv_q   <= 1'b1;
                 end
          FLUSH: if (cache_flush_ready_i[p]) begin
                   state_q <= DONE;
                   cfv_q   <= 1'b0;
                   fr_q    <= 1'b1;
                 end
          DONE:  state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end

    assign cache_flush_valid_o[p] = cfv_q;
    assign flush_ready_o[p]       = fr_q;

`ifdef PULP_ICACHE_FETCH_ADAPTER_PERF_EN
    logic [CntWidth-1:0] stall_q;

    always_ff @(posedge clk_i) begin
      if (rst_i || clear_cnt_i) begin
        stall_q <= '0;
      end else if (c_valid && !cache_ready_i[p] && !(&stall_q)) begin
        stall_q <= stall_q + 1'b1;
      end
    end

    assign stall_cnt_o[p*CntWidth +: CntWidth] = stall_q;
`else
    assign stall_cnt_o[p*CntWidth +: CntWidth] = '0;
`endif
  end

endmodule

// File: tb/tb_pulp_icache_fetch_adapter.sv
// Bench for pulp_icache_fetch_adapter: three instances cover ReqDepth 2/1/4 and RspCut 0/1.
module tb_pulp_icache_fetch_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int tests = 0;
  int fails = 0;

`ifdef PULP_ICACHE_FETCH_ADAPTER_PERF_EN
  localparam int ExpStall = 10;
`else
  localparam int ExpStall = 0;
`endif

  // Cache model: data and error derived from the requested address.
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a == 32'h200) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
  endfunction
  function automatic logic merr(input logic [31:0] a);
    return (a == 32'h200) || (a == 32'h110);
  endfunction

  // Instance A: 2 ports, ReqDepth 2, RspCut 0
  logic [1:0]  a_req, a_gnt, a_rv, a_re, a_fv, a_fr, a_cv, a_crdy, a_cre, a_cfv, a_cfr;
  logic [63:0] a_addr, a_rd, a_ca, a_crd;
  logic        a_clr;
  logic [31:0] a_cnt;
  assign a_crd = {mdata(a_ca[63:32]), mdata(a_ca[31:0])};
  assign a_cre = {merr(a_ca[63:32]), merr(a_ca[31:0])};

  // Instance B: ReqDepth 1, RspCut 0
  logic        b_req, b_gnt, b_rv, b_re, b_fv, b_fr, b_cv, b_crdy, b_cre, b_cfv, b_cfr, b_clr;
  logic [31:0] b_addr, b_rd, b_ca, b_crd;
  logic [15:0] b_cnt;
  assign b_crd = mdata(b_ca);
  assign b_cre = merr(b_ca);

  // Instance C: ReqDepth 4, RspCut 1
  logic        c_req, c_gnt, c_rv, c_re, c_fv, c_fr, c_cv, c_crdy, c_cre, c_cfv, c_cfr, c_clr;
  logic [31:0] c_addr, c_rd, c_ca, c_crd;
  logic [15:0] c_cnt;
  assign c_crd = mdata(c_ca);
  assign c_cre = merr(c_ca);

  pulp_icache_fetch_adapter #(.NumFetchPorts(2), .FetchAddrWidth(32), .FetchDataWidth(32),
                              .ReqDepth(2), .RspCut(0), .CntWidth(16)) u_a (
    .clk_i(clk), .rst_i(rst), .fetch_req_i(a_req), .fetch_addr_i(a_addr), .fetch_gnt_o(a_gnt),
    .fetch_rvalid_o(a_rv), .fetch_rdata_o(a_rd), .fetch_rerror_o(a_re), .flush_valid_i(a_fv),
    .flush_ready_o(a_fr), .cache_valid_o(a_cv), .cache_addr_o(a_ca), .cache_ready_i(a_crdy),
    .cache_rdata_i(a_crd), .cache_rerror_i(a_cre), .cache_flush_valid_o(a_cfv),
    .cache_flush_ready_i(a_cfr), .clear_cnt_i(a_clr), .stall_cnt_o(a_cnt));

  pulp_icache_fetch_adapter #(.NumFetchPorts(1), .FetchAddrWidth(32), .FetchDataWidth(32),
                              .ReqDepth(1), .RspCut(0), .CntWidth(16)) u_b (
    .clk_i(clk), .rst_i(rst), .fetch_req_i(b_req), .fetch_addr_i(b_addr), .fetch_gnt_o(b_gnt),
    .fetch_rvalid_o(b_rv), .fetch_rdata_o(b_rd), .fetch_rerror_o(b_re), .flush_valid_i(b_fv),
    .flush_ready_o(b_fr), .cache_valid_o(b_cv), .cache_addr_o(b_ca), .cache_ready_i(b_crdy),
    .cache_rdata_i(b_crd), .cache_rerror_i(b_cre), .cache_flush_valid_o(b_cfv),
    .cache_flush_ready_i(b_cfr), .clear_cnt_i(b_clr), .stall_cnt_o(b_cnt));

  pulp_icache_fetch_adapter #(.NumFetchPorts(1), .FetchAddrWidth(32), .FetchDataWidth(32),
                              .ReqDepth(4), .RspCut(1), .CntWidth(16)) u_c (
    .clk_i(clk), .rst_i(rst), .fetch_req_i(c_req), .fetch_addr_i(c_addr), .fetch_gnt_o(c_gnt),
    .fetch_rvalid_o(c_rv), .fetch_rdata_o(c_rd), .fetch_rerror_o(c_re), .flush_valid_i(c_fv),
    .flush_ready_o(c_fr), .cache_valid_o(c_cv), .cache_addr_o(c_ca), .cache_ready_i(c_crdy),
    .cache_rdata_i(c_crd), .cache_rerror_i(c_cre), .cache_flush_valid_o(c_cfv),
    .cache_flush_ready_i(c_cfr), .clear_cnt_i(c_clr), .stall_cnt_o(c_cnt));

  // Scoreboards: 0 = A port0, 1 = A port1, 2 = B, 3 = C
  logic [32:0] sbq [4][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mon_port(input int idx, input logic g, input logic [31:0] ad,
                          input logic rv, input logic [31:0] rd, input logic re);
    logic [32:0] e;
    if (rv) begin
      if (sbq[idx].size() == 0) begin
        chk($sformatf("rsp_unexpected_%0d", idx), 32'(rv), 32'd0);
      end else begin
        e = sbq[idx].pop_front();
        chk($sformatf("rsp_data_%0d", idx), rd, e[31:0]);
        chk($sformatf("rsp_err_%0d", idx), 32'(re), 32'(e[32]));
      end
    end
    if (g) sbq[idx].push_back({merr(ad), mdata(ad)});
  endtask

  task automatic half();
    @(negedge clk);
    mon_port(0, a_gnt[0], a_addr[31:0],  a_rv[0], a_rd[31:0],  a_re[0]);
    mon_port(1, a_gnt[1], a_addr[63:32], a_rv[1], a_rd[63:32], a_re[1]);
    mon_port(2, b_gnt, b_addr, b_rv, b_rd, b_re);
    mon_port(3, c_gnt, c_addr, c_rv, c_rd, c_re);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        rdy;
    logic        gnt;
    logic        rv;
    logic        cv;
  } vec_t;
  vec_t tbl [12];

  initial begin
    int k;
    int n;
    logic seen;

    tbl[0]  = '{1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h104, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 32'h108, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 32'h108, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 32'h10C, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h110, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 32'h114, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 32'h114, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 32'h114, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 32'h114, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 32'h114, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    a_req = '0; a_addr = '0; a_fv = '0; a_crdy = '0; a_cfr = '0; a_clr = 1'b0;
    b_req = 1'b0; b_addr = '0; b_fv = 1'b0; b_crdy = 1'b0; b_cfr = 1'b0; b_clr = 1'b0;
    c_req = 1'b0; c_addr = '0; c_fv = 1'b0; c_crdy = 1'b0; c_cfr = 1'b0; c_clr = 1'b0;
    nxt();
    nxt();
    half();
    chk("rst_a_cvalid", 32'(a_cv), 32'd0);
    chk("rst_a_rvalid", 32'(a_rv), 32'd0);
    chk("rst_a_rdata_lo", a_rd[31:0], 32'd0);
    chk("rst_a_cflush", 32'(a_cfv), 32'd0);
    chk("rst_a_flush_rdy", 32'(a_fr), 32'd0);
    chk("rst_a_cnt", a_cnt, 32'd0);
    chk("rst_c_rvalid", 32'(c_rv), 32'd0);
    chk("rst_c_rdata", c_rd, 32'd0);
    chk("rst_c_cnt", 32'(c_cnt), 32'd0);
    nxt();
    rst = 1'b0;

    // Streaming, full-FIFO and stall behaviour on A port 0; port 1 streams alongside.
    for (int i = 0; i < 12; i++) begin
      a_req[0]      = tbl[i].req;
      a_addr[31:0]  = tbl[i].addr;
      a_crdy[0]     = tbl[i].rdy;
      a_crdy[1]     = 1'b1;
      a_req[1]      = (i < 4);
      a_addr[63:32] = 32'h900 + 32'(4 * i);
      half();
      chk($sformatf("tbl_gnt_%0d", i),    32'(a_gnt[0]), 32'(tbl[i].gnt));
      chk($sformatf("tbl_rvalid_%0d", i), 32'(a_rv[0]),  32'(tbl[i].rv));
      chk($sformatf("tbl_cvalid_%0d", i), 32'(a_cv[0]),  32'(tbl[i].cv));
      nxt();
    end
    a_req = '0;

    // ReqDepth 1: grant every other cycle.
    b_crdy = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      b_req  = 1'b1;
      b_addr = 32'h300 + 32'(4 * k);
      half();
      chk($sformatf("b_gnt_%0d", i), 32'(b_gnt), 32'(i % 2 == 0));
      chk($sformatf("b_rvalid_%0d", i), 32'(b_rv), 32'(i % 2 == 1));
      if (b_gnt) k++;
      nxt();
    end
    b_req = 1'b0;
    chk("b_gnt_total", 32'(k), 32'd4);
    half();
    nxt();

    // ReqDepth 4 with the cache stalled for 10 valid cycles.
    c_crdy = 1'b0;
    k = 0;
    for (int i = 0; i < 11; i++) begin
      c_req  = 1'b1;
      c_addr = 32'h400 + 32'(4 * k);
      half();
      chk($sformatf("c_gnt_stall_%0d", i), 32'(c_gnt), 32'(i < 4));
      if (c_gnt) k++;
      nxt();
    end
    chk("c_gnt_count", 32'(k), 32'd4);
    c_req  = 1'b0;
    c_crdy = 1'b1;
    half();
    chk("c_stall_cnt", 32'(c_cnt), 32'(ExpStall));
    nxt();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      half();
      if (c_rv) n++;
      nxt();
    end
    chk("c_rsp_count", 32'(n), 32'd4);
    half();
    chk("c_stall_hold", 32'(c_cnt), 32'(ExpStall));
    nxt();
    c_clr = 1'b1;
    half();
    nxt();
    c_clr = 1'b0;
    half();
    chk("c_stall_clear", 32'(c_cnt), 32'd0);
    nxt();

    // RspCut 1: single fetch answered two cycles after the grant.
    c_req  = 1'b1;
    c_addr = 32'h200;
    half();
    chk("cut_gnt", 32'(c_gnt), 32'd1);
    chk("cut_rv_c0", 32'(c_rv), 32'd0);
    nxt();
    c_req = 1'b0;
    half();
    chk("cut_rv_c1", 32'(c_rv), 32'd0);
    nxt();
    half();
    chk("cut_rv_c2", 32'(c_rv), 32'd1);
    chk("cut_rdata", c_rd, 32'hDEADBEEF);
    chk("cut_rerror", 32'(c_re), 32'd1);
    nxt();
    half();
    chk("cut_rv_c3", 32'(c_rv), 32'd0);
    chk("cut_rdata_hold", c_rd, 32'hDEADBEEF);
    nxt();

    // Flush with three queued fetches and a stalled cache.
    c_crdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c_req  = 1'b1;
      c_addr = 32'h500 + 32'(4 * i);
      half();
      chk($sformatf("fl_fill_gnt_%0d", i), 32'(c_gnt), 32'd1);
      nxt();
    end
    c_addr = 32'h50C;
    c_fv   = 1'b1;
    half();
    chk("fl_prio_gnt", 32'(c_gnt), 32'd0);
    nxt();
    c_fv = 1'b0;
    for (int i = 0; i < 2; i++) begin
      half();
      chk("fl_drain_gnt", 32'(c_gnt), 32'd0);
      chk("fl_cflush_stalled", 32'(c_cfv), 32'd0);
      nxt();
    end
    c_crdy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      half();
      chk("fl_wait_gnt", 32'(c_gnt), 32'd0);
      chk("fl_cflush_early", 32'(c_cfv && sbq[3].size() != 0), 32'd0);
      if (c_cfv) seen = 1'b1;
      else nxt();
    end
    chk("fl_cflush_seen", 32'(seen), 32'd1);
    nxt();
    c_cfr = 1'b1;
    half();
    chk("fl_cflush_hold", 32'(c_cfv), 32'd1);
    chk("fl_rdy_early", 32'(c_fr), 32'd0);
    nxt();
    c_cfr = 1'b0;
    half();
    chk("fl_rdy_pulse", 32'(c_fr), 32'd1);
    chk("fl_cflush_drop", 32'(c_cfv), 32'd0);
    chk("fl_done_gnt", 32'(c_gnt), 32'd0);
    nxt();
    half();
    chk("fl_rdy_end", 32'(c_fr), 32'd0);
    chk("fl_resume_gnt", 32'(c_gnt), 32'd1);
    nxt();
    c_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half();
      nxt();
    end

    // Reset with two fetches queued on A port 0.
    a_crdy[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a_req[0]     = 1'b1;
      a_addr[31:0] = 32'h600 + 32'(4 * i);
      half();
      chk($sformatf("rst_fill_gnt_%0d", i), 32'(a_gnt[0]), 32'd1);
      nxt();
    end
    a_req[0] = 1'b0;
    rst = 1'b1;
    half();
    chk("rst_pre_cvalid", 32'(a_cv[0]), 32'd1);
    nxt();
    sbq[0].delete();
    rst = 1'b0;
    a_crdy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      half();
      chk($sformatf("rst_post_cvalid_%0d", i), 32'(a_cv[0]), 32'd0);
      chk($sformatf("rst_post_rvalid_%0d", i), 32'(a_rv[0]), 32'd0);
      chk($sformatf("rst_post_cnt_%0d", i), a_cnt, 32'd0);
      nxt();
    end

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sb_empty_%0d", i), 32'(sbq[i].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulp_icache_fetch_adapter.md
Name: pulp_icache_fetch_adapter

Overview:
- Parametrised per-port fetch adapter between core fetch interfaces (req/gnt/rvalid) and the shared instruction cache's valid/ready fetch ports.
- Generalises the single-entry request cut to:
  - a configurable-depth request FIFO per port,
  - an optional registered response path,
  - flush sequencing that drains outstanding fetches before forwarding a flush,
  - per-port stall counters.
- Instantiated once per cluster in front of the cache, carrying all NumFetchPorts channels.

Parameters:
- NumFetchPorts, 8, number of core fetch ports (>= 1).
- FetchAddrWidth, 32, fetch address width.
- FetchDataWidth, 32, fetch data width.
- ReqDepth, 2, request FIFO entries per port (1..8); 2 sustains one fetch per cycle.
- RspCut, 0, 1 = response data/error/rvalid registered (+1 cycle); 0 = combinational from cache.
- CntWidth, 16, stall counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- fetch_req_i  in  NumFetchPorts  core fetch request
- fetch_addr_i  in  NumFetchPorts*FetchAddrWidth  fetch address
- fetch_gnt_o  out  NumFetchPorts  request accepted
- fetch_rvalid_o  out  NumFetchPorts  response valid
- fetch_rdata_o  out  NumFetchPorts*FetchDataWidth  response data
- fetch_rerror_o  out  NumFetchPorts  response error
- flush_valid_i  in  NumFetchPorts  core flush request
- flush_ready_o  out  NumFetchPorts  flush complete
- cache_valid_o  out  NumFetchPorts  fetch to cache valid
- cache_addr_o  out  NumFetchPorts*FetchAddrWidth  fetch address to cache
- cache_ready_i  in  NumFetchPorts  cache accepts fetch and returns data same cycle
- cache_rdata_i  in  NumFetchPorts*FetchDataWidth  cache data
- cache_rerror_i  in  NumFetchPorts  cache error
- cache_flush_valid_o  out  NumFetchPorts  flush to cache
- cache_flush_ready_i  in  NumFetchPorts  cache flush done
- clear_cnt_i  in  1  clear all stall counters
- stall_cnt_o  out  NumFetchPorts*CntWidth  cycles with cache_valid_o & !cache_ready_i

Behaviour:
- Ports are fully independent; all rules below apply per port.
- Reset (rst_i high at a clock edge):
  - FIFO empty, count=0.
  - Flush FSM in IDLE.
  - Response register cleared; all outputs 0 in the following cycle (data outputs 0).
  - Counters 0.
  - Reset mid-operation discards all queued fetches; no rvalid is issued for them.
- Request side:
  - fetch_gnt_o = fetch_req_i & (count < ReqDepth) & (state==IDLE).
  - No combinational path from cache_ready_i to fetch_gnt_o: a full FIFO does not accept a push in the same cycle as a pop.
  - Granted address is pushed at the clock edge.
- Cache side:
  - cache_valid_o = count != 0; cache_addr_o = FIFO head.
  - Pop when cache_valid_o & cache_ready_i.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo ReqDepth; ReqDepth need not be a power of two.
- Response:
  - RspCut=0: fetch_rvalid_o = pop; rdata/rerror passed through from the cache.
  - RspCut=1: rvalid/rdata/rerror registered on pop, presented the next cycle for exactly one cycle. When no pop occurs, rdata holds its previous value.
  - Responses are always in request order. Earliest rvalid is one cycle after gnt with RspCut=0, two cycles with RspCut=1.
- Flush FSM:
  - IDLE -> DRAIN on flush_valid_i. Grants are blocked from the same cycle.
  - DRAIN -> FLUSH when count==0 and, if RspCut=1, no response is pending in the register.
  - FLUSH: cache_flush_valid_o=1; on cache_flush_ready_i go to DONE.
  - DONE: flush_ready_o=1 for one cycle, then -> IDLE.
  - Flush and req arriving in the same cycle: flush has priority, req not granted.
  - flush_valid_i dropping before DONE does not abort the sequence.
- Stall counter:
  - Increments each cycle with cache_valid_o & !cache_ready_i.
  - Saturates at 2^CntWidth-1.
  - clear_cnt_i has priority over increment (counter becomes 0).

Optional Feature:
- Macro PULP_ICACHE_FETCH_ADAPTER_PERF_EN.
- Defined: stall counters and clear_cnt_i logic are implemented as described above.
- Undefined: no counter flops; stall_cnt_o tied to 0 and clear_cnt_i ignored. All other behaviour is identical.

Test Plan:
- ReqDepth=2, RspCut=0, cache_ready_i=1, req held high with addresses 0x100,0x104,0x108 -> gnt every cycle; rvalid in cycles 1,2,3 with data for 0x100,0x104,0x108 in order.
- ReqDepth=1 with continuous req -> gnt every other cycle; throughput 1/2; no fetch lost.
- ReqDepth=4, cache_ready_i=0 for 10 cycles, req held high -> exactly 4 gnts, gnt then 0; stall_cnt_o=10. After ready rises, 4 in-order responses; clear_cnt_i -> stall_cnt_o=0 next cycle.
- RspCut=1, single fetch 0x200, cache returns 0xDEADBEEF with rerror=1 -> rvalid exactly two cycles after gnt with rdata=0xDEADBEEF and rerror=1.
- 3 fetches queued, cache_ready_i=0, flush_valid_i pulsed -> no new gnt; cache_flush_valid_o stays 0 until all 3 responses are delivered; then flush_valid high; cache_flush_ready_i one cycle later -> flush_ready_o pulses for one cycle, then grants resume.
- Assert rst_i with 2 queued fetches -> cache_valid_o=0, no rvalid, counters 0 from the next cycle.
